// File: rtl/rs_fu_pkg.sv
// Shared types and helpers for the functional-unit occupancy tracker:
// per-FU state encoding, default latency bound and the latency clamp.
package rs_fu_pkg;

    localparam int DEFAULT_MAX_LAT = 8;

    typedef enum logic {
        FU_IDLE = 1'b0,
        FU_BUSY = 1'b1
    } fu_state_e;

    // A zero-latency op still occupies the FU for one cycle; longer ops saturate at max_lat.
    function automatic int unsigned clamp_lat(input int unsigned lat, input int unsigned max_lat);
        if (lat == 0) begin
            return 1;
        end
        if (lat > max_lat) begin
            return max_lat;
        end
        return lat;
    endfunction

endpackage

// File: rtl/fu_busy_slot.sv
// Busy/idle tracker for one functional unit: owner RS, remaining cycles, issue pulse.
// Optional FU_EARLY_RELEASE_EN lets the FU accept a new op in its completion cycle.
module fu_busy_slot
    import rs_fu_pkg::*;
#(
    parameter int RS_IDX_WIDTH = 2,
    parameter int LAT_WIDTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_flush,
    input  logic                    i_load,
    input  logic [RS_IDX_WIDTH-1:0] i_load_rs_idx,
    input  logic [LAT_WIDTH-1:0]    i_load_lat,
    output logic                    o_available,
    output logic                    o_issue_valid,
    output logic [RS_IDX_WIDTH-1:0] o_issue_rs_idx,
    output logic                    o_done,
    output logic [RS_IDX_WIDTH-1:0] o_done_rs_idx
);

    fu_state_e               r_state, w_state_nxt;
    logic [LAT_WIDTH-1:0]    r_cnt, w_cnt_nxt;
    logic [RS_IDX_WIDTH-1:0] r_owner, w_owner_nxt;
    logic                    r_issue_pend, w_issue_pend_nxt;
    logic                    w_last;

    assign w_last = (r_state == FU_BUSY) && (r_cnt == LAT_WIDTH'(1));

    assign o_done         = w_last && !i_flush;
    assign o_done_rs_idx  = r_owner;
    assign o_issue_valid  = r_issue_pend;
    assign o_issue_rs_idx = r_owner;

`ifdef FU_EARLY_RELEASE_EN
    assign o_available = (r_state == FU_IDLE) || (w_last && !i_flush);
`else
    assign o_available = (r_state == FU_IDLE);
`endif

    // NOTE: every next-state signal gets a default first, so no path through the block infers a latch.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_owner_nxt      = r_owner;
        w_issue_pend_nxt = 1'b0;
        if (i_flush) begin
            w_state_nxt = FU_IDLE;
            w_cnt_nxt   = '0;
        end else if (i_load) begin
            w_state_nxt      = FU_BUSY;
            w_cnt_nxt        = i_load_lat;
            w_owner_nxt      = i_load_rs_idx;
            w_issue_pend_nxt = 1'b1;
        end else if (r_state == FU_BUSY) begin
            w_cnt_nxt = r_cnt - LAT_WIDTH'(1);
            if (w_last) begin
                w_state_nxt = FU_IDLE;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so all slots update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= FU_IDLE;
            r_cnt        <= '0;
            r_owner      <= '0;
            r_issue_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_owner      <= w_owner_nxt;
            r_issue_pend <= w_issue_pend_nxt;
        end
    end

endmodule

// File: rtl/fu_occupancy_tracker.sv
// Tracks functional-unit occupancy behind the RS scheduler: arbitrates dispatches,
// flags protocol conflicts (sticky), and reports availability, issue and completion.
module fu_occupancy_tracker
    import rs_fu_pkg::*;
#(
    parameter int NUM_OF_RS    = 4,
    parameter int NUM_OF_FU    = 2,
    parameter int MAX_LAT      = DEFAULT_MAX_LAT,
    parameter int FU_IDX_WIDTH = (NUM_OF_FU <= 1) ? 1 : $clog2(NUM_OF_FU),
    parameter int RS_IDX_WIDTH = (NUM_OF_RS <= 1) ? 1 : $clog2(NUM_OF_RS),
    parameter int LAT_WIDTH    = $clog2(MAX_LAT + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_OF_RS-1:0]    rs_dispatch_en,
    input  logic [FU_IDX_WIDTH-1:0] rs_fu_assign    [NUM_OF_RS],
    input  logic [LAT_WIDTH-1:0]    rs_latency      [NUM_OF_RS],
    input  logic                    flush,
    output logic [NUM_OF_FU-1:0]    fu_available,
    output logic [NUM_OF_FU-1:0]    fu_issue_valid,
    output logic [RS_IDX_WIDTH-1:0] fu_issue_rs_idx [NUM_OF_FU],
    output logic [NUM_OF_FU-1:0]    fu_done,
    output logic [RS_IDX_WIDTH-1:0] fu_done_rs_idx  [NUM_OF_FU],
    output logic                    err_conflict
);

    logic [NUM_OF_FU-1:0]    w_req, w_multi, w_load;
    logic [RS_IDX_WIDTH-1:0] w_win_idx [NUM_OF_FU];
    logic [LAT_WIDTH-1:0]    w_win_lat [NUM_OF_FU];
    logic                    w_bad_assign, w_conflict;
    logic                    r_err_conflict;

    // Lowest-index RS claims each FU; later requesters for the same FU are recorded as conflicts.
    always_comb begin
        w_req        = '0;
        w_multi      = '0;
        w_bad_assign = 1'b0;
        for (int f = 0; f < NUM_OF_FU; f++) begin
            w_win_idx[f] = '0;
            w_win_lat[f] = '0;
        end
        for (int r = 0; r < NUM_OF_RS; r++) begin
            if (rs_dispatch_en[r]) begin
                if (int'(rs_fu_assign[r]) >= NUM_OF_FU) begin
                    w_bad_assign = 1'b1;
                end
                for (int f = 0; f < NUM_OF_FU; f++) begin
                    if (int'(rs_fu_assign[r]) == f) begin
                        if (w_req[f]) begin
                            w_multi[f] = 1'b1;
                        end else begin
                            w_req[f]     = 1'b1;
                            w_win_idx[f] = RS_IDX_WIDTH'(r);
                            w_win_lat[f] = LAT_WIDTH'(clamp_lat(int'(rs_latency[r]), MAX_LAT));
                        end
                    end
                end
            end
        end
    end

    assign w_conflict   = w_bad_assign || (|w_multi) || (|(w_req & ~fu_available));
    assign w_load       = w_req & fu_available & {NUM_OF_FU{~flush}};
    assign err_conflict = r_err_conflict;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_conflict <= 1'b0;
        end else if (w_conflict) begin
            r_err_conflict <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_OF_FU; g++) begin : g_slot
        fu_busy_slot #(
            .RS_IDX_WIDTH (RS_IDX_WIDTH),
            .LAT_WIDTH    (LAT_WIDTH)
        ) u_slot (
            .clk            (clk),
            .rst            (rst),
            .i_flush        (flush),
            .i_load         (w_load[g]),
            .i_load_rs_idx  (w_win_idx[g]),
            .i_load_lat     (w_win_lat[g]),
            .o_available    (fu_available[g]),
            .o_issue_valid  (fu_issue_valid[g]),
            .o_issue_rs_idx (fu_issue_rs_idx[g]),
            .o_done         (fu_done[g]),
            .o_done_rs_idx  (fu_done_rs_idx[g])
        );
    end

endmodule

// File: tb/tb_fu_occupancy_tracker.sv
// Self-checking bench: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a cycle-timeline reference model.
module tb_fu_occupancy_tracker;

    localparam int NRS = 4;
    localparam int NFU = 2;
`ifdef FU_EARLY_RELEASE_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] rs_dispatch_en;
    logic [0:0] rs_fu_assign [NRS];
    logic [3:0] rs_latency   [NRS];
    logic       flush;
    logic [1:0] fu_available, fu_issue_valid, fu_done;
    logic [1:0] fu_issue_rs_idx [NFU];
    logic [1:0] fu_done_rs_idx  [NFU];
    logic       err_conflict;

    int n_checks = 0;
    int n_fail   = 0;

    fu_occupancy_tracker #(
        .NUM_OF_RS (NRS),
        .NUM_OF_FU (NFU),
        .MAX_LAT   (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rs_dispatch_en  (rs_dispatch_en),
        .rs_fu_assign    (rs_fu_assign),
        .rs_latency      (rs_latency),
        .flush           (flush),
        .fu_available    (fu_available),
        .fu_issue_valid  (fu_issue_valid),
        .fu_issue_rs_idx (fu_issue_rs_idx),
        .fu_done         (fu_done),
        .fu_done_rs_idx  (fu_done_rs_idx),
        .err_conflict    (err_conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge; outputs are then stable for sampling.
    task automatic step(input logic [3:0] en, input logic [3:0] fa, input logic [15:0] lat, input logic fl);
        @(negedge clk);
        rs_dispatch_en = en;
        for (int r = 0; r < NRS; r++) begin
            rs_fu_assign[r] = fa[r];
            rs_latency[r]   = lat[4*r +: 4];
        end
        flush = fl;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rs_dispatch_en = '0;
        flush = 1'b0;
        for (int r = 0; r < NRS; r++) begin
            rs_fu_assign[r] = '0;
            rs_latency[r]   = '0;
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  en;
        logic [3:0]  fa;
        logic [15:0] lat;
        logic [1:0]  avail;
        logic [1:0]  issue;
        logic [3:0]  issue_idx;
        logic [1:0]  done;
        logic [3:0]  done_idx;
        logic        err;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(logic [3:0] en, logic [3:0] fa, logic [15:0] lat, logic [1:0] avail,
                                logic [1:0] issue, logic [3:0] iidx, logic [1:0] done, logic [3:0] didx,
                                logic err);
        vec_t v;
        v.en = en; v.fa = fa; v.lat = lat; v.avail = avail; v.issue = issue;
        v.issue_idx = iidx; v.done = done; v.done_idx = didx; v.err = err;
        return v;
    endfunction

    // Reference model: each FU remembers the cycle its op was accepted and the clamped latency.
    int m_start [NFU];
    int m_lat   [NFU];
    int m_owner [NFU];
    bit m_act   [NFU];
    bit m_err;
    int cyc;

    function automatic int ref_clamp(int l);
        if (l == 0) return 1;
        if (l > 8) return 8;
        return l;
    endfunction

    function automatic bit m_last(int f);
        return m_act[f] && (cyc == m_start[f] + m_lat[f]);
    endfunction

    task automatic model_reset();
        for (int f = 0; f < NFU; f++) begin
            m_act[f] = 1'b0; m_start[f] = 0; m_lat[f] = 0; m_owner[f] = 0;
        end
        m_err = 1'b0;
        cyc   = 0;
    endtask

    task automatic model_check_and_advance();
        bit         av [NFU];
        bit         claimed [NFU];
        int         win [NFU];
        bit         confl;
        logic [1:0] e_av, e_is, e_dn;
        e_av = '0; e_is = '0; e_dn = '0;
        for (int f = 0; f < NFU; f++) begin
            av[f]   = !m_act[f] || (EARLY && m_last(f) && !flush);
            e_av[f] = av[f];
            e_is[f] = m_act[f] && (cyc == m_start[f] + 1);
            e_dn[f] = m_last(f) && !flush;
        end
        check($sformatf("rnd_avail c%0d", cyc), fu_available, e_av);
        check($sformatf("rnd_issue c%0d", cyc), fu_issue_valid, e_is);
        check($sformatf("rnd_done c%0d", cyc), fu_done, e_dn);
        check($sformatf("rnd_err c%0d", cyc), err_conflict, m_err);
        for (int f = 0; f < NFU; f++) begin
            if (e_is[f]) check($sformatf("rnd_issue_idx%0d c%0d", f, cyc), fu_issue_rs_idx[f], m_owner[f]);
            if (e_dn[f]) check($sformatf("rnd_done_idx%0d c%0d", f, cyc), fu_done_rs_idx[f], m_owner[f]);
        end
        confl = 1'b0;
        for (int f = 0; f < NFU; f++) begin claimed[f] = 1'b0; win[f] = 0; end
        for (int r = 0; r < NRS; r++) begin
            if (rs_dispatch_en[r]) begin
                int f = int'(rs_fu_assign[r]);
                if (f >= NFU || claimed[f]) begin
                    confl = 1'b1;
                end else begin
                    claimed[f] = 1'b1;
                    win[f]     = r;
                    if (!av[f]) confl = 1'b1;
                end
            end
        end
        if (confl) m_err = 1'b1;
        for (int f = 0; f < NFU; f++) begin
            if (m_last(f)) m_act[f] = 1'b0;
            if (flush) begin
                m_act[f] = 1'b0;
            end else if (claimed[f] && av[f]) begin
                m_act[f]   = 1'b1;
                m_start[f] = cyc;
                m_lat[f]   = ref_clamp(int'(rs_latency[win[f]]));
                m_owner[f] = win[f];
            end
        end
        cyc++;
    endtask

    initial begin
        rst = 1'b1;
        rs_dispatch_en = '0;
        flush = 1'b0;
        for (int r = 0; r < NRS; r++) begin
            rs_fu_assign[r] = '0;
            rs_latency[r]   = '0;
        end
        #2;
        check("reset_avail", fu_available, 2'b11);
        check("reset_issue", fu_issue_valid, 2'b00);
        check("reset_done", fu_done, 2'b00);
        check("reset_err", err_conflict, 1'b0);
        check("reset_idx0", fu_issue_rs_idx[0], 2'd0);

        // Latency-3 op, same-cycle FU1 contention, then latency 0 and 15 clamping.
        tbl[0]  = mk(4'b0010, 4'b0000, 16'h0030, 2'b11, 2'b00, 4'h0, 2'b00, 4'h0, 1'b0);
        tbl[1]  = mk(4'b0000, 4'b0000, 16'h0000, 2'b10, 2'b01, 4'h1, 2'b00, 4'h0, 1'b0);
        tbl[2]  = mk(4'b0000, 4'b0000, 16'h0000, 2'b10, 2'b00, 4'h0, 2'b00, 4'h0, 1'b0);
        tbl[3]  = mk(4'b0000, 4'b0000, 16'h0000, 2'b10, 2'b00, 4'h0, 2'b01, 4'h1, 1'b0);
        tbl[4]  = mk(4'b0101, 4'b0101, 16'h0502, 2'b11, 2'b00, 4'h0, 2'b00, 4'h0, 1'b0);
        tbl[5]  = mk(4'b0000, 4'b0000, 16'h0000, 2'b01, 2'b10, 4'h0, 2'b00, 4'h0, 1'b1);
        tbl[6]  = mk(4'b0000, 4'b0000, 16'h0000, 2'b01, 2'b00, 4'h0, 2'b10, 4'h0, 1'b1);
        tbl[7]  = mk(4'b1000, 4'b0000, 16'h0000, 2'b11, 2'b00, 4'h0, 2'b00, 4'h0, 1'b1);
        tbl[8]  = mk(4'b0000, 4'b0000, 16'h0000, 2'b10, 2'b01, 4'h3, 2'b01, 4'h3, 1'b1);
        tbl[9]  = mk(4'b0100, 4'b0100, 16'h0F00, 2'b11, 2'b00, 4'h0, 2'b00, 4'h0, 1'b1);
        tbl[10] = mk(4'b0000, 4'b0000, 16'h0000, 2'b01, 2'b10, 4'h8, 2'b00, 4'h0, 1'b1);
        for (int i = 11; i <= 16; i++)
            tbl[i] = mk(4'b0000, 4'b0000, 16'h0000, 2'b01, 2'b00, 4'h0, 2'b00, 4'h0, 1'b1);
        tbl[17] = mk(4'b0000, 4'b0000, 16'h0000, 2'b01, 2'b00, 4'h0, 2'b10, 4'h8, 1'b1);
        tbl[18] = mk(4'b0000, 4'b0000, 16'h0000, 2'b11, 2'b00, 4'h0, 2'b00, 4'h0, 1'b1);

        do_reset();
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].en, tbl[i].fa, tbl[i].lat, 1'b0);
            check($sformatf("tbl%0d_avail", i), fu_available, tbl[i].avail);
            check($sformatf("tbl%0d_issue", i), fu_issue_valid, tbl[i].issue);
            check($sformatf("tbl%0d_done", i), fu_done, tbl[i].done);
            check($sformatf("tbl%0d_err", i), err_conflict, tbl[i].err);
            for (int f = 0; f < NFU; f++) begin
                if (tbl[i].issue[f])
                    check($sformatf("tbl%0d_issue_idx%0d", i, f), fu_issue_rs_idx[f], tbl[i].issue_idx[2*f +: 2]);
                if (tbl[i].done[f])
                    check($sformatf("tbl%0d_done_idx%0d", i, f), fu_done_rs_idx[f], tbl[i].done_idx[2*f +: 2]);
            end
        end

        // Flush in FU0's completion cycle together with a dispatch to FU1.
        do_reset();
        step(4'b0001, 4'b0000, 16'h0002, 1'b0);
        step(4'b0000, 4'b0000, 16'h0000, 1'b0);
        check("flush_pre_issue", fu_issue_valid, 2'b01);
        step(4'b0010, 4'b0010, 16'h0030, 1'b1);
        check("flush_done_suppressed", fu_done, 2'b00);
        step(4'b0000, 4'b0000, 16'h0000, 1'b0);
        check("flush_after_avail", fu_available, 2'b11);
        check("flush_after_issue", fu_issue_valid, 2'b00);
        check("flush_after_done", fu_done, 2'b00);
        check("flush_after_err", err_conflict, 1'b0);

        // Asynchronous reset with four cycles left on FU0.
        do_reset();
        step(4'b0001, 4'b0000, 16'h0006, 1'b0);
        step(4'b0000, 4'b0000, 16'h0000, 1'b0);
        step(4'b0000, 4'b0000, 16'h0000, 1'b0);
        step(4'b0000, 4'b0000, 16'h0000, 1'b0);
        check("rst_pre_avail", fu_available, 2'b10);
        #1 rst = 1'b1;
        #1;
        check("rst_async_avail", fu_available, 2'b11);
        check("rst_async_issue", fu_issue_valid, 2'b00);
        check("rst_async_done", fu_done, 2'b00);
        check("rst_async_err", err_conflict, 1'b0);
        check("rst_async_idx0", fu_issue_rs_idx[0], 2'd0);
        check("rst_async_didx0", fu_done_rs_idx[0], 2'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("rst_hold_done%0d", k), fu_done, 2'b00);
        end
        rst = 1'b0;
        step(4'b0100, 4'b0100, 16'h0100, 1'b0);
        check("rst_rel_avail", fu_available, 2'b11);
        step(4'b0000, 4'b0000, 16'h0000, 1'b0);
        check("rst_rel_issue", fu_issue_valid, 2'b10);
        check("rst_rel_issue_idx", fu_issue_rs_idx[1], 2'd2);
        check("rst_rel_done", fu_done, 2'b10);
        check("rst_rel_done_idx", fu_done_rs_idx[1], 2'd2);
        step(4'b0000, 4'b0000, 16'h0000, 1'b0);
        check("rst_rel_idle", fu_available, 2'b11);

`ifdef FU_EARLY_RELEASE_EN
        // Back-to-back ops on FU0 with zero bubble.
        do_reset();
        step(4'b0010, 4'b0000, 16'h0020, 1'b0);
        step(4'b0000, 4'b0000, 16'h0000, 1'b0);
        check("early_issue1", fu_issue_valid, 2'b01);
        step(4'b1000, 4'b0000, 16'h2000, 1'b0);
        check("early_avail_done_cycle", fu_available, 2'b11);
        check("early_done1", fu_done, 2'b01);
        step(4'b0000, 4'b0000, 16'h0000, 1'b0);
        check("early_issue2", fu_issue_valid, 2'b01);
        check("early_issue2_idx", fu_issue_rs_idx[0], 2'd3);
        check("early_busy", fu_available, 2'b10);
        check("early_err", err_conflict, 1'b0);
        step(4'b0000, 4'b0000, 16'h0000, 1'b0);
        check("early_done2", fu_done, 2'b01);
        check("early_done2_idx", fu_done_rs_idx[0], 2'd3);
        step(4'b0000, 4'b0000, 16'h0000, 1'b0);
        check("early_idle", fu_available, 2'b11);
`endif

        // Random traffic in several reset-separated blocks so err_conflict is exercised both ways.
        for (int blk = 0; blk < 6; blk++) begin
            do_reset();
            model_reset();
            for (int c = 0; c < 80; c++) begin
                logic [3:0]  en;
                logic [3:0]  fa;
                logic [15:0] lat;
                logic        fl;
                for (int r = 0; r < NRS; r++) begin
                    en[r]          = ($urandom_range(0, 9) < 2 + blk / 2);
                    fa[r]          = 1'($urandom_range(0, 1));
                    lat[4*r +: 4]  = 4'($urandom_range(0, 15));
                end
                fl = ($urandom_range(0, 15) == 0);
                step(en, fa, lat, fl);
                model_check_and_advance();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fu_occupancy_tracker.md
Name: fu_occupancy_tracker

Overview:
- Sits directly downstream of the RS-to-FU scheduler and closes the loop back to it.
- Consumes the per-RS dispatch enables, FU assignments and op latencies, and tracks the busy/idle state and remaining cycles of every functional unit.
- Produces `fu_available` for the scheduler, a registered issue pulse per FU, and a completion pulse tagged with the originating RS index.

Parameters:
- NUM_OF_RS, 4, number of reservation stations.
- NUM_OF_FU, 2, number of functional units tracked.
- MAX_LAT, 8, maximum supported execution latency in cycles.
- FU_IDX_WIDTH, (NUM_OF_FU<=1)?1:$clog2(NUM_OF_FU), FU index width.
- RS_IDX_WIDTH, (NUM_OF_RS<=1)?1:$clog2(NUM_OF_RS), RS index width.
- LAT_WIDTH, $clog2(MAX_LAT+1), latency/counter width.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- rs_dispatch_en  in  NUM_OF_RS  per-RS dispatch strobe from the scheduler.
- rs_fu_assign  in  FU_IDX_WIDTH x NUM_OF_RS  target FU per RS (unpacked array).
- rs_latency  in  LAT_WIDTH x NUM_OF_RS  execution latency of the op in each RS.
- flush  in  1  squash all in-flight ops (branch mispredict).
- fu_available  out  NUM_OF_FU  FU may accept a dispatch this cycle.
- fu_issue_valid  out  NUM_OF_FU  one-cycle pulse: op started on FU.
- fu_issue_rs_idx  out  RS_IDX_WIDTH x NUM_OF_FU  RS index owning the FU.
- fu_done  out  NUM_OF_FU  one-cycle pulse: op on FU completes this cycle.
- fu_done_rs_idx  out  RS_IDX_WIDTH x NUM_OF_FU  RS index of completing op.
- err_conflict  out  1  sticky protocol-violation flag.

Behaviour:
- Reset: asynchronous, active-high.
  - All FUs go to IDLE with counters at 0 and owner index at 0.
  - Outputs while reset is held: fu_available all 1s; fu_issue_valid, fu_done and err_conflict all 0; index outputs 0.
  - Reset asserted mid-operation aborts in-flight ops immediately; no done pulse is produced.
- Per-FU FSM states: IDLE and BUSY.
  - IDLE to BUSY: at the edge ending cycle T, when some RS has rs_dispatch_en=1 and rs_fu_assign equal to this FU.
  - On that edge: owner is latched; cnt is set to the effective latency; issue_pend is set.
- Issue pulse: in cycle T+1, fu_issue_valid=1 for exactly one cycle and fu_issue_rs_idx shows the owner.
  - fu_issue_rs_idx holds the owner value while BUSY.
- Countdown: while BUSY, cnt decrements by 1 each edge.
  - fu_done is combinational: BUSY and cnt==1.
  - fu_done_rs_idx equals the owner.
  - The edge that consumes cnt==1 returns the FU to IDLE.
- Latency L gives fu_issue_valid at T+1, fu_done at T+L, and the FU is IDLE at T+L+1.
- Latency clamp: rs_latency=0 is treated as 1; rs_latency>MAX_LAT is clamped to MAX_LAT.
- fu_available (macro off): equals state==IDLE.
- Conflicts: err_conflict is set and stays set until reset. The two conflict cases are:
  - Dispatch targeting a BUSY FU (not released): the dispatch is ignored and the FU state is unchanged.
  - Two or more RS dispatching to the same FU in one cycle: the lowest RS index wins and the others are dropped.
  - An rs_fu_assign value >= NUM_OF_FU with dispatch_en=1 is also a conflict and is ignored.
- Flush: synchronous, and overrides same-cycle dispatch.
  - At the edge all FUs go to IDLE and cnt is cleared.
  - fu_done is suppressed combinationally in the flush cycle.
  - fu_issue_valid is 0 the cycle after.
- Dispatches to different FUs in the same cycle are fully independent.

Optional Feature:
- Macro: FU_EARLY_RELEASE_EN.
- Defined: fu_available = IDLE or (BUSY and cnt==1 and not flush).
  - The scheduler may dispatch to the FU in its done cycle T+L.
  - The FU reloads at that edge and stays BUSY, giving back-to-back issue with zero bubble.
  - The new op is not treated as a conflict.
- Undefined: fu_available = IDLE only, giving one bubble cycle between ops on an FU.

Decomposition:
- Package rs_fu_pkg holds:
  - the fu_state_e enum (FU_IDLE, FU_BUSY);
  - the helper function that computes the clamped latency;
  - a shared default MAX_LAT constant.
- Sub-module fu_busy_slot, instantiated once per FU via generate, holds the FSM, cnt, owner and issue_pend for that FU.
- The top level holds:
  - dispatch decode and arbitration (lowest-index RS wins);
  - conflict detection;
  - the sticky err_conflict register.

Test Plan:
1. Reset, then RS1 dispatches to FU0 with latency 3 at cycle 0. Expect fu_issue_valid[0]=1 with fu_issue_rs_idx[0]=1 at cycle 1. Expect fu_done[0]=1 with fu_done_rs_idx[0]=1 at cycle 3. fu_available[0] is 0 in cycles 1..3 and 1 from cycle 4 (macro off).
2. RS0 and RS2 both target FU1 in the same cycle. Expect only RS0 to be issued and err_conflict=1 from the next cycle until reset.
3. Latency 0 and latency 15 (MAX_LAT=8). Expect done 1 cycle and 8 cycles after dispatch respectively.
4. Flush in the cycle FU0 would signal done (cnt==1), together with a new dispatch to FU1. Expect fu_done[0]=0, both FUs IDLE the next cycle, and no issue pulse.
5. Assert rst while FU0 has 4 cycles remaining. Expect all outputs at reset values immediately with no done pulse; after release, a dispatch works normally.
6. With FU_EARLY_RELEASE_EN, dispatch at the done cycle of a latency-2 op. Expect the new fu_issue_valid on the following cycle, FU stays BUSY, and err_conflict stays 0.
